// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The Sub signal exists only when PIPE_ADDER_SUB_EN is defined.
interface pipe_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef PIPE_ADDER_SUB_EN
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
`else
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per registered stage, global-enable stall.
// Optional subtract mode enabled by defining PIPE_ADDER_SUB_EN.
module pipe_adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
endmodule

module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES");
  end

  // Register 0 holds the captured operands; register k+1 holds the result of
  // slice k, so the output register is index STAGES.
  logic [STAGES:0]             vld_pipe_q, vld_pipe_d;
  logic [STAGES:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES:0]             c_q, c_d;
  logic [STAGES-1:0][CHUNK-1:0] s_ch;
  logic [STAGES-1:0]           c_nx;
  logic [WIDTH-1:0]            b_in;
  logic                        c_in;
  logic                        stall;

`ifdef PIPE_ADDER_SUB_EN
  assign b_in = bus.sub ? ~bus.b   : bus.b;
  assign c_in = bus.sub ? ~bus.cin : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    pipe_adder_stage #(.CHUNK(CHUNK)) u_stg (
      .a_i (a_q[k][k*CHUNK +: CHUNK]),
      .b_i (b_q[k][k*CHUNK +: CHUNK]),
      .c_i (c_q[k]),
      .s_o (s_ch[k]),
      .c_o (c_nx[k])
    );
  end

  assign stall        = vld_pipe_q[STAGES] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    c_d        = c_q;
    if (!stall) begin
      vld_pipe_d[0] = bus.in_valid;
      a_d[0]        = bus.a;
      b_d[0]        = b_in;
      c_d[0]        = c_in;
      s_d[0]        = '0;
      for (int k = 0; k < STAGES; k++) begin
        vld_pipe_d[k+1] = vld_pipe_q[k];
        a_d[k+1]        = a_q[k];
        b_d[k+1]        = b_q[k];
        c_d[k+1]        = c_nx[k];
        s_d[k+1]        = s_q[k];
        s_d[k+1][k*CHUNK +: CHUNK] = s_ch[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      c_q        <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      c_q        <= c_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.sum       = s_q[STAGES];
  assign bus.cout      = c_q[STAGES];
  // Operand sign bits ride to the end so overflow sees the effective B.
  assign bus.ovf = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1]) &&
                   (s_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);

  logic unused_ok;
  assign unused_ok = ^{a_q[STAGES][WIDTH-2:0], b_q[STAGES][WIDTH-2:0]};
endmodule

// File: tb/tb_pipe_adder.sv
// Directed + randomized bench for pipe_adder against an arithmetic reference model.
module tb_pipe_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus ();
  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   lat_chk;
  bit   acc_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit ci, input bit sb, input int acc);
    exp_t   e;
    longint ua = a;
    longint ub = b;
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint lc = ci;
    longint ru, rs;
    if (sb) begin
      ru = ua - ub - lc;
      rs = sa - sbv - lc;
      e.cout = (ru >= 0);
    end else begin
      ru = ua + ub + lc;
      rs = sa + sbv + lc;
      e.cout = (ru >= 65536);
    end
    e.sum = ru[W-1:0];
    e.ovf = (rs > 32767) || (rs < -32768);
    e.acc = acc;
    return e;
  endfunction

  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit ci, input bit sb, input bit ordy);
    logic ov, ir;
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = ci;
`ifdef PIPE_ADDER_SUB_EN
    bus.sub       = sb;
`endif
    bus.out_ready = ordy;
    #1;
    ov = bus.out_valid;
    ir = bus.in_ready;
    chk("in_ready", {31'd0, ir}, {31'd0, !(ov && !ordy)});
    if (lat_chk)
      chk("out_valid_timing", {31'd0, ov},
          {31'd0, (q.size() > 0 && q[0].acc + S + 1 == cyc)});
    if (ov) begin
      if (q.size() == 0) chk("spurious_out_valid", {31'd0, ov}, 32'd0);
      else begin
        chk("sum",  {16'd0, bus.sum}, {16'd0, q[0].sum});
        chk("cout", {31'd0, bus.cout}, {31'd0, q[0].cout});
        chk("ovf",  {31'd0, bus.ovf},  {31'd0, q[0].ovf});
        if (ordy) void'(q.pop_front());
      end
    end
    acc_flag = v && ir;
    if (acc_flag) q.push_back(model(a, b, ci, sb, cyc));
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] va, vb;
    bit vc, vs;
    int n, guard;

    rst_n = 1'b0;
    lat_chk = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h4321;
    bus.cin = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // First result latency and carry boundary cases
    step(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

`ifdef PIPE_ADDER_SUB_EN
    step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0010, 16'h0003, 1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
`endif

    // Alternating bubbles: out_valid timing is checked against acceptance cycle
    for (int i = 0; i < 10; i++)
      step((i % 2) == 0, W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
    repeat (6) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Back-to-back random stream with random backpressure
    lat_chk = 1'b0;
    n = 0;
    guard = 0;
    va = W'($urandom); vb = W'($urandom); vc = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
    vs = 1'($urandom);
`else
    vs = 1'b0;
`endif
    while (n < 20 && guard < 500) begin
      step(1'b1, va, vb, vc, vs, 1'($urandom));
      if (acc_flag) begin
        n++;
        va = W'($urandom); vb = W'($urandom); vc = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
        vs = 1'($urandom);
`endif
      end
      guard++;
    end
    chk("stream_accepted", n, 20);
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("stream_drained", q.size(), 0);

    // Reset with results in flight
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, bus.sum}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    q.delete();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    repeat (8) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined N-bit ripple-carry adder built from registered carry-chunk stages, with a valid/ready handshake on input and output. It takes an operand pair plus carry-in per accepted transfer and delivers Sum, Cout and signed overflow exactly STAGES cycles later. It sits between operand sources and the datapath consumers as the team's general-purpose wide adder, replacing chains of single-bit full-adder instances.

## Interface
- WIDTH, 16: operand and sum width in bits; must be ≥ 2.
- STAGES, 4: pipeline stages; must divide WIDTH evenly; CHUNK = WIDTH/STAGES bits added per stage.
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  reset, asynchronous assert, active-low; clears all state immediately.
- In_valid  input  1  operand transfer offered.
- In_ready  output  1  block can accept an operand transfer this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in, added at bit 0.
- Sub  input  1  subtract select; present only when PIPE_ADDER_SUB_EN is defined.
- Out_valid  output  1  result valid.
- Out_ready  input  1  consumer accepts the result this cycle.
- Sum  output  WIDTH  result bits.
- Cout  output  1  carry out of bit WIDTH-1.
- Ovf  output  1  signed (two's-complement) overflow.

## Operation
- Input transfer: In_valid && In_ready at a rising edge. Output transfer: Out_valid && Out_ready at a rising edge.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and B plus the registered carry from stage k-1. Stage 0 uses Cin as its carry.
- Operand bits not yet consumed travel forward with the carry. Completed sum chunks also travel forward. Each stage holds a valid bit.
- Result: Sum = (A + B + Cin) mod 2^WIDTH. Cout = bit WIDTH of the full (WIDTH+1)-bit sum.
- Ovf = (A[MSB] == B'[MSB]) && (Sum[MSB] != A[MSB]), where B' is the effective B operand.
- Stall rule: the pipeline is global-enable. stall = Out_valid && !Out_ready.
  - On stall, every stage register holds.
  - Otherwise, every stage advances one position, and stage 0 loads from the input on an input transfer; if there is no input transfer, stage 0 loads an invalid bubble.
- In_ready = !stall. This is combinational from Out_valid and Out_ready only; it never depends on In_valid.
- Bubbles propagate as invalid entries. Results leave in acceptance order. No result is dropped or duplicated.
- Reset mid-operation: all in-flight results are discarded. No output transfer follows until new inputs are accepted after reset release.

## Timing
- Reset values: Out_valid=0, Sum=0, Cout=0, Ovf=0. Every internal valid bit is 0. In_ready=1 while Rst_n=0 and after release.
- Latency: an input accepted at edge t gives Out_valid=1 with its result after edge t+STAGES, if there is no stall.
- Throughput: one result per cycle while Out_ready=1.
- Simultaneous output transfer and input transfer in the same cycle is legal, and the pipeline advances.
- When Out_valid=1 and Out_ready=0, Sum, Cout and Ovf hold stable, and In_ready=0, until the output transfer.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.

## Configuration
- PIPE_ADDER_SUB_EN defined:
  - The Sub port exists and is sampled with the operands.
  - Sub=1 computes A - B - Cin as A + ~B + !Cin. Cout is then the inverted borrow (1 = no borrow).
  - Ovf uses ~B as B'.
- Not defined:
  - There is no Sub port; the block is add-only with B' = B.
  - The RTL contains no inversion logic.

## Test plan
- Reset: hold Rst_n=0 with In_valid=1 → Out_valid=0, Sum=0, In_ready=1. Release, then send A=16'h0001, B=16'h0001, Cin=0 → Sum=16'h0002, Cout=0, Ovf=0, exactly 4 cycles after acceptance.
- Full carry ripple across all stage boundaries: A=16'hFFFF, B=16'h0000, Cin=1 → Sum=16'h0000, Cout=1, Ovf=0. Also A=16'h7FFF, B=16'h0001, Cin=0 → Sum=16'h8000, Ovf=1.
- Streaming with backpressure: 20 back-to-back random vectors with Out_ready toggled pseudo-randomly → results match the reference model, in order. In_ready is low exactly on stall cycles, and outputs stay stable while stalled.
- Bubbles: send vectors on alternate cycles with Out_ready=1 → Out_valid follows the same alternating pattern delayed by 4 cycles.
- Reset mid-flight: accept 3 vectors, assert Rst_n=0 for 1 cycle → Out_valid=0 immediately and no stale result appears afterwards.
- With PIPE_ADDER_SUB_EN: Sub=1, A=16'h0005, B=16'h0007, Cin=0 → Sum=16'hFFFE, Cout=0. A=16'h8000, B=16'h0001 → Sum=16'h7FFF, Ovf=1, Cout=1.
